wash_phase_timer: RTL and testbench

- Timing scheduler for the washing machine controller: generates the phase-done inputs tf, tw, td, tr, ts that the controller consumes.
- The requester starts one phase at a time by code; the block loads that phase's duration, counts prescaled ticks and pulses the matching done line.
- Door-open pauses the count; abort cancels it.
- Sits between the controller FSM and the clock domain, replacing bench-driven timer strobes.

---
 rtl/wash_pkg.sv | 42 ++++
 rtl/wash_tick_prescaler.sv | 30 +++
 rtl/wash_phase_timer.sv | 189 ++++++++++++++++++
 tb/tb_wash_phase_timer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/wash_pkg.sv
// rtl/wash_pkg.sv - phase codes, timer state encoding and default durations for the wash phase timer
package wash_pkg;

  localparam logic [2:0] PH_FILL  = 3'd1;
  localparam logic [2:0] PH_WASH  = 3'd2;
  localparam logic [2:0] PH_DRAIN = 3'd3;
  localparam logic [2:0] PH_RINSE = 3'd4;
  localparam logic [2:0] PH_SPIN  = 3'd5;

  localparam int DEF_FILL_TICKS  = 100;
  localparam int DEF_WASH_TICKS  = 300;
  localparam int DEF_DRAIN_TICKS = 80;
  localparam int DEF_RINSE_TICKS = 200;
  localparam int DEF_SPIN_TICKS  = 150;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } timer_state_e;

  function automatic logic phase_legal(input logic [2:0] sel);
    return (sel >= PH_FILL) && (sel <= PH_SPIN);
  endfunction

  // Bit 0 is FILL (tf) up to bit 4 SPIN (ts).
  function automatic logic [4:0] phase_onehot(input logic [2:0] sel);
    logic [4:0] v;
    v = '0;
    case (sel)
      PH_FILL:  v = 5'b00001;
      PH_WASH:  v = 5'b00010;
      PH_DRAIN: v = 5'b00100;
      PH_RINSE: v = 5'b01000;
      PH_SPIN:  v = 5'b10000;
      default:  v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/wash_tick_prescaler.sv
// rtl/wash_tick_prescaler.sv - clk-to-tick divider with enable, clear and hold
// tick is high while the count sits at PRESCALE-1, so the next enabled edge wraps.
module wash_tick_prescaler #(
  parameter int PRESCALE = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/wash_phase_timer.sv
// rtl/wash_phase_timer.sv - phase duration timer producing the tf/tw/td/tr/ts done pulses
// Define WASH_TIMER_CFG_EN for run-time writable phase durations.
module wash_phase_timer
  import wash_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int PRESCALE    = 1000,
  parameter int FILL_TICKS  = DEF_FILL_TICKS,
  parameter int WASH_TICKS  = DEF_WASH_TICKS,
  parameter int DRAIN_TICKS = DEF_DRAIN_TICKS,
  parameter int RINSE_TICKS = DEF_RINSE_TICKS,
  parameter int SPIN_TICKS  = DEF_SPIN_TICKS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             phase_start,
  input  logic [2:0]       phase_sel,
  input  logic             abort,
  input  logic             door,
  input  logic             cfg_wr,
  input  logic [2:0]       cfg_sel,
  input  logic [CNT_W-1:0] cfg_data,
  output logic             tf,
  output logic             tw,
  output logic             td,
  output logic             tr,
  output logic             ts,
  output logic             busy,
  output logic             paused,
  output logic [CNT_W-1:0] remaining,
  output logic             err
);

  timer_state_e     state_q, state_n;
  logic [CNT_W-1:0] rem_q, rem_n;
  logic [2:0]       phase_q, phase_n;
  logic [4:0]       done_q, done_n;
  logic             err_q, err_n;
  logic             busy_q, paused_q;
  logic             pre_en, pre_clr, tick;
  logic             cfg_err;
  logic [CNT_W-1:0] load_dur;
  logic [CNT_W-1:0] dur [1:5];

`ifdef WASH_TIMER_CFG_EN
  // A running phase keeps the count it loaded; writes only affect later loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dur[1] <= CNT_W'(FILL_TICKS);
      dur[2] <= CNT_W'(WASH_TICKS);
      dur[3] <= CNT_W'(DRAIN_TICKS);
      dur[4] <= CNT_W'(RINSE_TICKS);
      dur[5] <= CNT_W'(SPIN_TICKS);
    end else if (cfg_wr) begin
      case (cfg_sel)
        PH_FILL:  dur[1] <= cfg_data;
        PH_WASH:  dur[2] <= cfg_data;
        PH_DRAIN: dur[3] <= cfg_data;
        PH_RINSE: dur[4] <= cfg_data;
        PH_SPIN:  dur[5] <= cfg_data;
        default:  ;
      endcase
    end
  end

  assign cfg_err = cfg_wr && !phase_legal(cfg_sel);
`else
  logic cfg_unused;

  always_comb begin
    dur[1] = CNT_W'(FILL_TICKS);
    dur[2] = CNT_W'(WASH_TICKS);
    dur[3] = CNT_W'(DRAIN_TICKS);
    dur[4] = CNT_W'(RINSE_TICKS);
    dur[5] = CNT_W'(SPIN_TICKS);
  end

  assign cfg_err    = 1'b0;
  assign cfg_unused = ^{cfg_wr, cfg_sel, cfg_data};
`endif

  always_comb begin
    load_dur = '0;
    case (phase_sel)
      PH_FILL:  load_dur = dur[1];
      PH_WASH:  load_dur = dur[2];
      PH_DRAIN: load_dur = dur[3];
      PH_RINSE: load_dur = dur[4];
      PH_SPIN:  load_dur = dur[5];
      default:  load_dur = '0;
    endcase
  end

  wash_tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (pre_en),
    .clr (pre_clr),
    .tick(tick)
  );

  // RUN and PAUSE share one step: the edge that releases the door also counts,
  // so each paused cycle lengthens the phase by exactly one cycle.
  always_comb begin
    state_n = state_q;
    rem_n   = rem_q;
    phase_n = phase_q;
    err_n   = cfg_err;
    done_n  = '0;
    pre_en  = 1'b0;
    pre_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!abort && phase_start) begin
          if (phase_legal(phase_sel)) begin
            state_n = ST_RUN;
            rem_n   = load_dur;
            phase_n = phase_sel;
            pre_clr = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      ST_RUN, ST_PAUSE: begin
        if (phase_start) err_n = 1'b1;
        if (abort) begin
          state_n = ST_IDLE;
          rem_n   = '0;
          pre_clr = 1'b1;
        end else if (door) begin
          state_n = ST_PAUSE;
        end else if (rem_q == '0) begin
          state_n = ST_DONE;
        end else begin
          state_n = ST_RUN;
          pre_en  = 1'b1;
          if (tick) begin
            if (rem_q == CNT_W'(1)) begin
              state_n = ST_DONE;
              rem_n   = '0;
            end else begin
              rem_n = rem_q - 1'b1;
            end
          end
        end
      end
      ST_DONE: begin
        if (phase_start) err_n = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    if (state_n == ST_DONE) done_n = phase_onehot(phase_n);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rem_q    <= '0;
      phase_q  <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      paused_q <= 1'b0;
    end else begin
      state_q  <= state_n;
      rem_q    <= rem_n;
      phase_q  <= phase_n;
      done_q   <= done_n;
      err_q    <= err_n;
      busy_q   <= (state_n != ST_IDLE);
      paused_q <= (state_n == ST_PAUSE);
    end
  end

  assign tf        = done_q[0];
  assign tw        = done_q[1];
  assign td        = done_q[2];
  assign tr        = done_q[3];
  assign ts        = done_q[4];
  assign busy      = busy_q;
  assign paused    = paused_q;
  assign remaining = rem_q;
  assign err       = err_q;

endmodule

// File: tb/tb_wash_phase_timer.sv
// tb/tb_wash_phase_timer.sv - directed self-checking bench for wash_phase_timer
module tb_wash_phase_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        phase_start = 1'b0;
  logic [2:0]  phase_sel = 3'd0;
  logic        abort = 1'b0;
  logic        door = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [2:0]  cfg_sel = 3'd0;
  logic [15:0] cfg_data = 16'd0;
  logic        tf, tw, td, tr, ts, busy, paused, err;
  logic [15:0] remaining;
  logic [4:0]  dv;

  int n_checks = 0;
  int n_fail   = 0;
  int first_k;
  logic [4:0] first_v;

  assign dv = {ts, tr, td, tw, tf};

  wash_phase_timer #(
    .CNT_W(16), .PRESCALE(4), .FILL_TICKS(3), .WASH_TICKS(3),
    .DRAIN_TICKS(0), .RINSE_TICKS(5), .SPIN_TICKS(10)
  ) dut (
    .clk(clk), .rst(rst), .phase_start(phase_start), .phase_sel(phase_sel),
    .abort(abort), .door(door), .cfg_wr(cfg_wr), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .tf(tf), .tw(tw), .td(td), .tr(tr), .ts(ts),
    .busy(busy), .paused(paused), .remaining(remaining), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [2:0] sel);
    phase_sel   = sel;
    phase_start = 1'b1;
    step();
    phase_start = 1'b0;
  endtask

  // Steps n edges and reports the first edge (1-based) showing any done pulse, or -1.
  task automatic run_edges(input int n, output int fk, output logic [4:0] fv);
    fk = -1;
    fv = '0;
    for (int k = 1; k <= n; k++) begin
      step();
      if (fk < 0 && dv != 5'b0) begin
        fk = k;
        fv = dv;
      end
    end
  endtask

  initial begin
    #3;
    chk("reset_busy", busy, 0);
    chk("reset_remaining", remaining, 0);
    chk("reset_done", dv, 0);
    chk("reset_err", err, 0);
    chk("reset_paused", paused, 0);
    step();
    rst = 1'b0;

    // FILL, 3 ticks of 4 clocks: done on the 12th edge after sampling
    start(3'd1);
    chk("fill_busy", busy, 1);
    chk("fill_rem0", remaining, 3);
    run_edges(4, first_k, first_v);
    chk("fill_rem_e4", remaining, 2);
    chk("fill_early_a", first_k, -1);
    run_edges(4, first_k, first_v);
    chk("fill_rem_e8", remaining, 1);
    chk("fill_early_b", first_k, -1);
    run_edges(3, first_k, first_v);
    chk("fill_early_c", first_k, -1);
    step();
    chk("fill_done_e12", dv, 5'b00001);
    chk("fill_rem_e12", remaining, 0);
    chk("fill_busy_done", busy, 1);
    step();
    chk("fill_done_clear", dv, 0);
    chk("fill_idle", busy, 0);

    // WASH with the door open for 5 cycles after edge 2
    start(3'd2);
    run_edges(2, first_k, first_v);
    door = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("wash_paused", paused, 1);
      chk("wash_rem_frozen", remaining, 3);
    end
    door = 1'b0;
    run_edges(10, first_k, first_v);
    chk("wash_done_edge", first_k, 10);
    chk("wash_done_line", first_v, 5'b00010);
    chk("wash_unpaused", paused, 0);
    step();
    chk("wash_idle", busy, 0);

    // SPIN aborted mid-run
    start(3'd5);
    run_edges(5, first_k, first_v);
    chk("spin_rem_e5", remaining, 9);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_rem", remaining, 0);
    chk("abort_paused", paused, 0);
    run_edges(60, first_k, first_v);
    chk("abort_no_done", first_k, -1);

    // Rejected start while FILL runs, then illegal code in IDLE
    start(3'd1);
    run_edges(3, first_k, first_v);
    start(3'd2);
    chk("busy_reject_err", err, 1);
    chk("busy_reject_rem", remaining, 2);
    chk("busy_reject_busy", busy, 1);
    step();
    chk("busy_reject_err_clr", err, 0);
    run_edges(7, first_k, first_v);
    chk("reject_fill_edge", first_k, 7);
    chk("reject_fill_line", first_v, 5'b00001);
    step();
    chk("reject_fill_idle", busy, 0);
    start(3'd7);
    chk("illegal_err", err, 1);
    chk("illegal_busy", busy, 0);
    step();
    chk("illegal_err_clr", err, 0);

    // abort together with start in IDLE drops the start silently
    abort = 1'b1;
    start(3'd1);
    abort = 1'b0;
    chk("abort_start_busy", busy, 0);
    chk("abort_start_err", err, 0);

    // DRAIN with zero duration
    start(3'd3);
    chk("drain_busy", busy, 1);
    chk("drain_rem", remaining, 0);
    chk("drain_no_done", dv, 0);
    step();
    chk("drain_done", dv, 5'b00100);
    step();
    chk("drain_done_clr", dv, 0);
    chk("drain_idle", busy, 0);

    // Start with the door already open: RUN, then PAUSE
    door = 1'b1;
    start(3'd1);
    chk("door_start_busy", busy, 1);
    chk("door_start_run", paused, 0);
    step();
    chk("door_start_pause", paused, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    door  = 1'b0;
    chk("door_abort_busy", busy, 0);
    chk("door_abort_paused", paused, 0);

`ifdef WASH_TIMER_CFG_EN
    cfg_wr  = 1'b1;
    cfg_sel = 3'd0;
    step();
    cfg_wr = 1'b0;
    chk("cfg_illegal_err", err, 1);
    step();
    start(3'd4);
    chk("cfg_rinse_rem", remaining, 5);
    run_edges(2, first_k, first_v);
    cfg_wr   = 1'b1;
    cfg_sel  = 3'd4;
    cfg_data = 16'd2;
    step();
    cfg_wr = 1'b0;
    chk("cfg_write_err", err, 0);
    chk("cfg_rem_kept", remaining, 5);
    run_edges(17, first_k, first_v);
    chk("cfg_old_edge", first_k, 17);
    chk("cfg_old_line", first_v, 5'b01000);
    step();
    start(3'd4);
    chk("cfg_new_rem", remaining, 2);
    run_edges(8, first_k, first_v);
    chk("cfg_new_edge", first_k, 8);
    chk("cfg_new_line", first_v, 5'b01000);
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
